// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helper function for the FIFO slice
//
// Purpose : default sizing constants (one SD sector) and a clog2 helper used
//           to size pointers and level counters.
// Ports   : none (package).
package fifo_pkg;

  localparam int SECTOR_BYTES     = 512;
  localparam int DEFAULT_DEPTH    = 512;
  localparam int DEFAULT_BLK_SIZE = SECTOR_BYTES;

  // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - simple dual-port memory with registered read port
//
// Purpose : FIFO storage, one write port and one registered read port, no
//           reset so it maps onto block RAM.
// Ports   : clk    - clock, rising edge
//           we     - write enable
//           waddr  - write address
//           wdata  - write data
//           re     - read enable (rdata holds when low)
//           raddr  - read address
//           rdata  - registered read data
module sync_fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with level, thresholds, block-ready and sticky errors
//
// Purpose : buffers the UART byte stream for the SD data engine. Reports
//           level, almost-full/almost-empty, a block-ready flag once BLK_SIZE
//           words are stored, and sticky overflow/underflow errors.
// Ports   : clk, rst (async active-high)
//           flush               - synchronous clear of contents (highest priority)
//           wr_en, wr_data      - write side; full, almost_full
//           rd_en               - read side; rd_data, rd_valid (1-cycle latency)
//           empty, almost_empty, level, blk_rdy - status, all post-edge
//           overflow, underflow - sticky errors; err_clr clears them
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4,
  parameter int BLK_SIZE  = DEFAULT_BLK_SIZE,
  localparam int AW       = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              almost_full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              almost_empty,
  output logic [AW:0]       level,
  output logic              blk_rdy,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam logic [AW:0] ONE_L    = (AW+1)'(1);
  localparam logic [AW:0] AFULL_L  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_L = (AW+1)'(AEMPTY_TH);
  localparam logic [AW:0] BLK_L    = (AW+1)'(BLK_SIZE);

  logic [AW:0]       wptr, rptr;
  logic [AW:0]       wptr_nxt, rptr_nxt, level_nxt;
  logic              wr_acc, rd_acc;
  logic              full_nxt, empty_nxt;
  logic              data_seen;
  logic [DATA_W-1:0] ram_q;

  always_comb begin
    wr_acc    = !flush && wr_en && !full;
    rd_acc    = !flush && rd_en && !empty;
    wptr_nxt  = wptr;
    rptr_nxt  = rptr;
    level_nxt = level;
    if (flush) begin
      wptr_nxt  = '0;
      rptr_nxt  = '0;
      level_nxt = '0;
    end else begin
      if (wr_acc) wptr_nxt = wptr + ONE_L;
      if (rd_acc) rptr_nxt = rptr + ONE_L;
      case ({wr_acc, rd_acc})
        2'b10:   level_nxt = level + ONE_L;
        2'b01:   level_nxt = level - ONE_L;
        default: level_nxt = level;
      endcase
    end
    // Pointers carry one extra lap bit: equal low bits with differing lap
    // bits means the writer is a full lap ahead.
    full_nxt  = (wptr_nxt[AW] != rptr_nxt[AW]) &&
                (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]);
    empty_nxt = (wptr_nxt == rptr_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      level        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      blk_rdy      <= 1'b0;
      rd_valid     <= 1'b0;
      data_seen    <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wptr         <= wptr_nxt;
      rptr         <= rptr_nxt;
      level        <= level_nxt;
      full         <= full_nxt;
      empty        <= empty_nxt;
      almost_full  <= (level_nxt >= AFULL_L);
      almost_empty <= (level_nxt <= AEMPTY_L);
      blk_rdy      <= (level_nxt >= BLK_L);
      rd_valid     <= rd_acc;
      if (rd_acc) data_seen <= 1'b1;
      // Setting takes precedence over err_clr; flushed requests are not errors.
      if (!flush && wr_en && full) overflow <= 1'b1;
      else if (err_clr)            overflow <= 1'b0;
      if (!flush && rd_en && empty) underflow <= 1'b1;
      else if (err_clr)             underflow <= 1'b0;
    end
  end

  // The RAM read register has no reset; until the first accepted read its
  // output is masked so rd_data reads as zero out of reset.
  assign rd_data = data_seen ? ram_q : '0;

  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr[AW-1:0]),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rptr[AW-1:0]),
    .rdata (ram_q)
  );

endmodule
